// File: rtl/uart_frame_pkg.sv
// Shared constants and FSM encoding for the framed UART receiver.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE    = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// 16x8 payload buffer: one write port, one registered read port.
module uart_frame_buf (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Wr_En,
    input  logic [3:0] i_Wr_Addr,
    input  logic [7:0] i_Wr_Data,
    input  logic [3:0] i_Rd_Addr,
    output logic [7:0] o_Rd_Data
);

    logic [7:0] mem [16];

    // Storage is deliberately left without reset.
    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            o_Rd_Data <= '0;
        end else begin
            o_Rd_Data <= mem[i_Rd_Addr];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser for SOF/LEN/payload/CHK packets arriving from a byte-level UART receiver.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic [3:0] i_Rd_Addr,
    input  logic       i_Frame_Ack,
    output logic       o_Frame_Valid,
    output logic [4:0] o_Frame_Len,
    output logic [7:0] o_Rd_Data,
    output logic       o_Err_Pulse,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun
);

    localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CLKS - 1);

    state_t           state;
    logic [4:0]       len;
    logic [3:0]       idx;
    logic [7:0]       xor_acc;
    logic [CNT_W-1:0] to_cnt;

    logic counting;
    logic timeout_hit;
    logic is_sof;
    logic last_byte;
    logic wr_en;

    assign counting    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign timeout_hit = counting && !i_Rx_DV && (to_cnt == TO_MAX);
    assign is_sof      = (i_Rx_Byte == SOF_BYTE);
    assign last_byte   = ({1'b0, idx} + 5'd1) == len;
    assign wr_en       = (state == S_PAYLOAD) && i_Rx_DV;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state         <= S_IDLE;
            len           <= '0;
            idx           <= '0;
            xor_acc       <= '0;
            to_cnt        <= '0;
            o_Frame_Valid <= 1'b0;
            o_Frame_Len   <= '0;
            o_Err_Pulse   <= 1'b0;
            o_Err_Code    <= ERR_NONE;
            o_Overrun     <= 1'b0;
        end else begin
            o_Err_Pulse <= 1'b0;
            o_Err_Code  <= ERR_NONE;
            o_Overrun   <= 1'b0;

            // Saturating inter-byte timer; every strobe restarts it.
            if (i_Rx_DV) begin
                to_cnt <= '0;
            end else if (counting && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (i_Rx_DV && is_sof) begin
                        state   <= S_LEN;
                        xor_acc <= '0;
                        idx     <= '0;
                    end
                end
                S_LEN: begin
                    if (i_Rx_DV) begin
                        xor_acc <= i_Rx_Byte;
                        len     <= i_Rx_Byte[4:0];
                        idx     <= '0;
                        if (i_Rx_Byte == 8'd0) begin
                            state <= S_CHK;
                        end else if (i_Rx_Byte <= 8'(MAX_LEN)) begin
                            state <= S_PAYLOAD;
                        end else begin
                            state       <= S_IDLE;
                            o_Err_Pulse <= 1'b1;
                            o_Err_Code  <= ERR_LEN;
                        end
                    end else if (timeout_hit) begin
                        state       <= S_IDLE;
                        o_Err_Pulse <= 1'b1;
                        o_Err_Code  <= ERR_TIMEOUT;
                    end
                end
                S_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        xor_acc <= xor_acc ^ i_Rx_Byte;
                        idx     <= idx + 4'd1;
                        if (last_byte) begin
                            state <= S_CHK;
                        end
                    end else if (timeout_hit) begin
                        state       <= S_IDLE;
                        o_Err_Pulse <= 1'b1;
                        o_Err_Code  <= ERR_TIMEOUT;
                    end
                end
                S_CHK: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == xor_acc) begin
                            state         <= S_HOLD;
                            o_Frame_Valid <= 1'b1;
                            o_Frame_Len   <= len;
                        end else begin
                            state       <= S_IDLE;
                            o_Err_Pulse <= 1'b1;
                            o_Err_Code  <= ERR_CHK;
                        end
                    end else if (timeout_hit) begin
                        state       <= S_IDLE;
                        o_Err_Pulse <= 1'b1;
                        o_Err_Code  <= ERR_TIMEOUT;
                    end
                end
                S_HOLD: begin
                    // A coincident strobe is handled as if the parser were already idle.
                    if (i_Frame_Ack) begin
                        o_Frame_Valid <= 1'b0;
                        if (i_Rx_DV && is_sof) begin
                            state   <= S_LEN;
                            xor_acc <= '0;
                            idx     <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (i_Rx_DV) begin
                        o_Overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_frame_buf u_buf (
        .i_Clock   (i_Clock),
        .i_Rst_L   (i_Rst_L),
        .i_Wr_En   (wr_en),
        .i_Wr_Addr (idx),
        .i_Wr_Data (i_Rx_Byte),
        .i_Rd_Addr (i_Rd_Addr),
        .o_Rd_Data (o_Rd_Data)
    );

endmodule
